// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operand request with valid/ready,
// result and flags with valid/ready.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut;
  logic             Z;
  logic             V;
  logic             N;
  logic             Err;

  modport master (
    output in_valid, A, B, ALU_Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, CarryOut, Z, V, N, Err
  );

  modport slave (
    input  in_valid, A, B, ALU_Sel, out_ready,
    output in_ready, out_valid, ALU_Out, CarryOut, Z, V, N, Err
  );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake. Single-cycle ops finish one
// cycle after accept; shifts iterate one bit per cycle and MUL runs a
// shift-add loop of WIDTH iterations. One operation in flight at a time.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input logic   clk,
  input logic   rst,
  seq_alu_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_NOR = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_EQ  = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1011;
  localparam logic [3:0] OP_SHR = 4'b1100;

  localparam logic [SHW-1:0] CNT_FULL = SHW'(WIDTH);
  localparam logic [WIDTH:0] WIDTH_V  = (WIDTH + 1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  // Low half is the shift working value; full width is the MUL product
  // register (multiplier starts in the low half and is shifted out).
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               sc_q, sc_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               z_q, z_d;
  logic               v_q, v_d;
  logic               n_q, n_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_c;
  logic               fin_v;
  logic               fin_e;

  assign add_w   = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w   = {1'b0, a_q} - {1'b0, b_q};
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);

  // Final result and flags from the captured operands / finished iteration.
  always_comb begin
    fin_res = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    fin_e   = 1'b0;
    case (op_q)
      OP_ADD: begin
        fin_res = add_w[WIDTH-1:0];
        fin_c   = add_w[WIDTH];
        fin_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        fin_res = sub_w[WIDTH-1:0];
        fin_c   = sub_w[WIDTH];
        fin_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_NOR: fin_res = ~(a_q | b_q);
      OP_SLT: fin_res[0] = (a_q < b_q);
      OP_EQ:  fin_res[0] = (a_q == b_q);
      OP_SHL, OP_SHR: begin
        fin_res = prod_q[WIDTH-1:0];
        fin_c   = sc_q;
      end
      OP_MUL: begin
        fin_res = prod_q[WIDTH-1:0];
        fin_c   = |prod_q[2*WIDTH-1:WIDTH];
      end
      default: fin_e = 1'b1;
    endcase
  end

  // Next-state and datapath updates: capture, iterate, finalize, release.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    sc_d      = sc_q;
    res_d     = res_q;
    carry_d   = carry_q;
    z_d       = z_q;
    v_d       = v_q;
    n_d       = n_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = bus.ALU_Sel;
          sc_d    = 1'b0;
          cnt_d   = '0;
          prod_d  = {{WIDTH{1'b0}}, bus.B};
          state_d = BUSY;
          if (bus.ALU_Sel == OP_SHL || bus.ALU_Sel == OP_SHR) begin
            prod_d = {{WIDTH{1'b0}}, bus.A};
            cnt_d  = ({1'b0, bus.B} >= WIDTH_V) ? CNT_FULL : bus.B[SHW-1:0];
          end else if (bus.ALU_Sel == OP_MUL) begin
            cnt_d = CNT_FULL;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          res_d   = fin_res;
          carry_d = fin_c;
          v_d     = fin_v;
          err_d   = fin_e;
          z_d     = (fin_res == '0);
          n_d     = fin_res[WIDTH-1];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          case (op_q)
            OP_SHL: begin
              sc_d                = prod_q[WIDTH-1];
              prod_d[WIDTH-1:0]   = {prod_q[WIDTH-2:0], 1'b0};
            end
            OP_SHR: begin
              sc_d                = prod_q[0];
              prod_d[WIDTH-1:0]   = {1'b0, prod_q[WIDTH-1:1]};
            end
            default: prod_d = {mul_sum, prod_q[WIDTH-1:1]};
          endcase
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      sc_q        <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      z_q         <= 1'b1;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      sc_q        <= sc_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      z_q         <= z_d;
      v_q         <= v_d;
      n_q         <= n_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ALU_Out   = res_q;
  assign bus.CarryOut  = carry_q;
  assign bus.Z         = z_q;
  assign bus.V         = v_q;
  assign bus.N         = n_q;
  assign bus.Err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed table-driven bench for seq_alu at WIDTH=8, plus hand-written
// sequences for reset abort and output backpressure.
module tb_seq_alu;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_NOR = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_EQ  = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1011;
  localparam logic [3:0] OP_SHR = 4'b1100;
  localparam int NVEC = 21;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       v;
    logic       n;
    logic       e;
  } vec_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  vec_t vecs [NVEC];

  seq_alu_if #(.WIDTH(8)) bus ();

  seq_alu #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Issue one request, measure accept-to-valid latency, compare, then pop.
  task automatic run_vec(input vec_t v);
    int cyc;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = v.a;
    bus.B        = v.b;
    bus.ALU_Sel  = v.op;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.out_valid) break;
    end
    $display("op=%b A=%h B=%h lat=%0d out=%h C=%b Z=%b V=%b N=%b Err=%b",
             v.op, v.a, v.b, cyc, bus.ALU_Out, bus.CarryOut, bus.Z, bus.V, bus.N, bus.Err);
    chk("out_valid", bus.out_valid, 1);
    chk("latency", cyc, v.lat);
    chk("ALU_Out", bus.ALU_Out, v.res);
    chk("CarryOut", bus.CarryOut, v.c);
    chk("Z", bus.Z, v.z);
    chk("V", bus.V, v.v);
    chk("N", bus.N, v.n);
    chk("Err", bus.Err, v.e);
    chk("in_ready_done", bus.in_ready, 0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("pop_out_valid", bus.out_valid, 0);
    chk("pop_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    logic [7:0] held;
    int cyc;
    n_pass  = 0;
    n_total = 0;

    //        op      a      b      lat res    c  z  v  n  e
    vecs[0]  = '{OP_ADD, 8'hF0, 8'h20, 1, 8'h10, 1, 0, 0, 0, 0};
    vecs[1]  = '{OP_ADD, 8'h7F, 8'h01, 1, 8'h80, 0, 0, 1, 1, 0};
    vecs[2]  = '{OP_SUB, 8'h03, 8'h05, 1, 8'hFE, 1, 0, 0, 1, 0};
    vecs[3]  = '{OP_SUB, 8'h05, 8'h05, 1, 8'h00, 0, 1, 0, 0, 0};
    vecs[4]  = '{OP_SUB, 8'h80, 8'h01, 1, 8'h7F, 0, 0, 1, 0, 0};
    vecs[5]  = '{OP_NOR, 8'h0F, 8'hF0, 1, 8'h00, 0, 1, 0, 0, 0};
    vecs[6]  = '{OP_NOR, 8'h0A, 8'h05, 1, 8'hF0, 0, 0, 0, 1, 0};
    vecs[7]  = '{OP_SLT, 8'h03, 8'h05, 1, 8'h01, 0, 0, 0, 0, 0};
    vecs[8]  = '{OP_SLT, 8'h85, 8'h03, 1, 8'h00, 0, 1, 0, 0, 0};
    vecs[9]  = '{OP_EQ,  8'h5A, 8'h5A, 1, 8'h01, 0, 0, 0, 0, 0};
    vecs[10] = '{OP_EQ,  8'h05, 8'h06, 1, 8'h00, 0, 1, 0, 0, 0};
    vecs[11] = '{OP_MUL, 8'd15, 8'd17, 9, 8'hFF, 0, 0, 0, 1, 0};
    vecs[12] = '{OP_MUL, 8'd16, 8'd16, 9, 8'h00, 1, 1, 0, 0, 0};
    vecs[13] = '{OP_MUL, 8'd0,  8'd0,  9, 8'h00, 0, 1, 0, 0, 0};
    vecs[14] = '{OP_SHL, 8'h81, 8'd3,  4, 8'h08, 0, 0, 0, 0, 0};
    vecs[15] = '{OP_SHR, 8'h81, 8'd9,  9, 8'h00, 1, 1, 0, 0, 0};
    vecs[16] = '{OP_SHL, 8'h81, 8'd0,  1, 8'h81, 0, 0, 0, 1, 0};
    vecs[17] = '{OP_SHR, 8'h81, 8'd1,  2, 8'h40, 1, 0, 0, 0, 0};
    vecs[18] = '{OP_SHL, 8'h81, 8'd8,  9, 8'h00, 1, 1, 0, 0, 0};
    vecs[19] = '{4'b1111, 8'h12, 8'h34, 1, 8'h00, 0, 1, 0, 0, 1};
    vecs[20] = '{4'b0000, 8'hFF, 8'hFF, 1, 8'h00, 0, 1, 0, 0, 1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.ALU_Sel   = '0;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ALU_Out", bus.ALU_Out, 0);
    chk("rst_Z", bus.Z, 1);
    chk("rst_C", bus.CarryOut, 0);
    chk("rst_VNE", {bus.V, bus.N, bus.Err}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Reset in the middle of a MUL: outputs return to reset values at once.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 8'd15;
    bus.B        = 8'd17;
    bus.ALU_Sel  = OP_MUL;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mul_busy_in_ready", bus.in_ready, 0);
    rst = 1'b1;
    #1;
    $display("reset during MUL: in_ready=%b out_valid=%b out=%h Z=%b",
             bus.in_ready, bus.out_valid, bus.ALU_Out, bus.Z);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_Z", bus.Z, 1);
    chk("abort_ALU_Out", bus.ALU_Out, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) cyc++;
    end
    chk("abort_no_result", cyc, 0);
    run_vec(vecs[0]);

    // Backpressure: result held while a competing request is presented.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 8'h7F;
    bus.B        = 8'h01;
    bus.ALU_Sel  = OP_ADD;
    @(posedge clk);
    #1;
    bus.A       = 8'h01;
    bus.B       = 8'h01;
    bus.ALU_Sel = OP_SUB;
    @(posedge clk);
    #1;
    chk("bp_out_valid", bus.out_valid, 1);
    held = bus.ALU_Out;
    chk("bp_first", held, 8'h80);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      $display("backpressure cycle %0d: out_valid=%b in_ready=%b out=%h V=%b N=%b",
               k, bus.out_valid, bus.in_ready, bus.ALU_Out, bus.V, bus.N);
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_out", bus.ALU_Out, 8'h80);
      chk("bp_hold_flags", {bus.CarryOut, bus.Z, bus.V, bus.N, bus.Err}, 5'b00110);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_pop_in_ready", bus.in_ready, 1);
    chk("bp_keep_out", bus.ALU_Out, 8'h80);
    @(posedge clk);
    #1;
    chk("bp_ignored_req", {bus.in_ready, bus.out_valid}, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered ALU: the next generation of the team's 8-bit combinational ALU.
- Keeps that ALU's opcode map and flag semantics, adds WIDTH generalisation and a valid/ready handshake.
- Adds multi-cycle iterative multiply and variable-distance shifts (one bit per cycle), plus overflow/negative/error flags.
- Sits between the datapath control FSM and the register file; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 4..32).
- SHW, $clog2(WIDTH)+1, width of the internal shift/multiply iteration counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request
- A  input  WIDTH  first operand
- B  input  WIDTH  second operand / shift distance
- ALU_Sel  input  4  operation select
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- ALU_Out  output  WIDTH  registered result
- CarryOut  output  1  carry / borrow / multiply-overflow
- Z  output  1  zero flag
- V  output  1  signed overflow (ADD/SUB only, else 0)
- N  output  1  ALU_Out[WIDTH-1]
- Err  output  1  illegal opcode flag

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=1; out_valid=0; ALU_Out=0; CarryOut=0; Z=1; V=0; N=0; Err=0; counter=0.
- Reset mid-operation aborts the operation, discards the result and returns to IDLE immediately.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterative ops; in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Accept: in_valid && in_ready on an edge captures A, B and ALU_Sel.
- Inputs are ignored outside IDLE.
- Opcodes (same encodings as the existing ALU):
  - 0001 ADD: {CarryOut,ALU_Out}=A+B; V=signed overflow.
  - 0010 SUB: ALU_Out=A-B mod 2^WIDTH; CarryOut=(A<B) unsigned borrow; V=signed overflow.
  - 0011 NOR: ~(A|B).
  - 1000 SLT: unsigned A<B gives 1, else 0 (zero-extended).
  - 0110 EQ: A==B gives 1, else 0.
  - 1011 SHL: logical shift left by B, one bit per cycle; CarryOut=last bit shifted out (0 if B=0).
  - 1100 SHR: logical shift right by B, one bit per cycle; CarryOut=last bit shifted out (0 if B=0).
  - 0100 MUL: unsigned shift-add, WIDTH iterations; ALU_Out=low WIDTH bits; CarryOut=1 if high half nonzero.
  - Any other opcode: ALU_Out=0, Err=1, all other flags 0 except Z=1.
- Latency, with accept on edge t:
  - Single-cycle ops and illegal opcodes: IDLE→DONE; out_valid high after edge t+1.
  - Shifts: n=min(B,WIDTH) BUSY cycles; out_valid after edge t+1+n; B=0 behaves as a single-cycle op.
  - B≥WIDTH gives result 0 after WIDTH cycles.
  - MUL: exactly WIDTH BUSY cycles; out_valid after edge t+1+WIDTH, for any operands.
- DONE holds ALU_Out and all flags stable until out_valid && out_ready.
  - On that edge go to IDLE, out_valid=0, in_ready=1.
  - Outputs keep their last values until the next result.
  - No new accept can occur on the same edge (in_ready=0 in DONE).
- Z=(ALU_Out==0) and N=ALU_Out[WIDTH-1] are computed on the final result, registered with it.
- Flags are only meaningful while out_valid=1.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, WIDTH=8: rst pulse during MUL BUSY → out_valid=0, in_ready=1 immediately; Z=1, ALU_Out=0.
- ADD A=8'hF0, B=8'h20 → out_valid one cycle after accept; ALU_Out=8'h10, CarryOut=1, V=0, Z=0. ADD 8'h7F+8'h01 → 8'h80, V=1, N=1.
- SUB A=3, B=5 → ALU_Out=8'hFE, CarryOut=1, N=1. SUB A=5, B=5 → 0, Z=1, CarryOut=0.
- MUL A=8'd15, B=8'd17 → 255 after exactly 9 cycles, CarryOut=0. MUL 8'd16 × 8'd16 → 0, CarryOut=1, Z=1.
- SHL A=8'h81, B=3 → 8'h08 after 4 cycles, CarryOut=0. SHR A=8'h81, B=9 → 0 after 9 cycles, Z=1. SHL with B=0 → A, 1-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles → result/flags stable, in_ready=0 and new in_valid ignored. Opcode 4'b1111 → Err=1, Z=1, ALU_Out=0.
